// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake bundle for mem_bus_arbiter: port 0 (instruction fetch)
// and port 1 (data load/store).
interface mem_bus_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;

    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    // master = requesters, slave = the arbiter
    modport master (
        output p0_req, p0_addr,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata
    );

    modport slave (
        input  p0_req, p0_addr,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-port controller for the shared 64-bit ROM/RAM bus: fixed-width
// read/write strobes, tri-state write data, registered read data and one-cycle acks.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    mem_bus_arbiter_if.slave    ports,
    output logic [31:0]         bus_address,
    inout  wire  [63:0]         bus_data,
    output logic                mem_read,
    output logic                mem_write,
    output logic                busy
);
    localparam int unsigned W     = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               gnt;
    logic               last_served;
    logic [63:0]        wdata_q;
    logic               grant_c;
    logic               grant_we_c;

    // On a tie the port that was not served last wins; otherwise whichever port asks.
    assign grant_c    = (ports.p0_req && ports.p1_req) ? ~last_served : ports.p1_req;
    assign grant_we_c = grant_c & ports.p1_we;

    // Write data goes on the bus only while the write strobe is up.
    assign bus_data = mem_write ? wdata_q : 'z;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            gnt            <= 1'b0;
            last_served    <= 1'b1;
            wdata_q        <= '0;
            bus_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            busy           <= 1'b0;
            ports.p0_ack   <= 1'b0;
            ports.p1_ack   <= 1'b0;
            ports.p0_rdata <= '0;
            ports.p1_rdata <= '0;
        end else begin
            ports.p0_ack <= 1'b0;
            ports.p1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ports.p0_req || ports.p1_req) begin
                        gnt         <= grant_c;
                        bus_address <= grant_c ? ports.p1_addr : ports.p0_addr;
                        wdata_q     <= ports.p1_wdata;
                        cnt         <= CNT_W'(W - 1);
                        mem_read    <= ~grant_we_c;
                        mem_write   <= grant_we_c;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Last strobe cycle: capture read data and schedule the ack.
                        if (mem_read) begin
                            if (gnt) ports.p1_rdata <= bus_data;
                            else     ports.p0_rdata <= bus_data;
                        end
                        if (gnt) ports.p1_ack <= 1'b1;
                        else     ports.p0_ack <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        last_served <= gnt;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
